adrv9001_tdd_ctrl: RTL and testbench

ADRV9001_TDD_CTRL -- requirements
Module: adrv9001_tdd_ctrl

---
 rtl/adrv9001_pkg.sv | 14 +
 rtl/adrv9001_tdd_window.sv | 41 ++++
 rtl/adrv9001_tdd_ctrl.sv | 164 ++++++++++++++++
 tb/tb_adrv9001_tdd_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_pkg.sv
// Shared definitions for the ADRV9001 TDD controller.
// Holds the FSM state encoding and default counter widths.
package adrv9001_pkg;

  localparam int CNT_WIDTH_DEF  = 32;
  localparam int NFRM_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tdd_state_e;

endpackage

// File: rtl/adrv9001_tdd_window.sv
// Per-channel TDD window: registered enable and SERDES reset.
// Ports: clk_i/rst_i, cnt_i (frame counter), on_i/off_i/ssi_on_i
// (latched window), run_i (window gate), enable_o, serdes_rst_o.
module adrv9001_tdd_window
  import adrv9001_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic [CNT_WIDTH-1:0] on_i,
  input  logic [CNT_WIDTH-1:0] off_i,
  input  logic [CNT_WIDTH-1:0] ssi_on_i,
  input  logic                 run_i,
  output logic                 enable_o,
  output logic                 serdes_rst_o
);

  logic en_d, en_q;
  logic srst_d, srst_q;

  always_comb begin
    en_d   = run_i && (cnt_i >= on_i) && (cnt_i < off_i);
    srst_d = !(run_i && (cnt_i >= ssi_on_i) && (cnt_i < off_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q   <= 1'b0;
      srst_q <= 1'b1;
    end else begin
      en_q   <= en_d;
      srst_q <= srst_d;
    end
  end

  assign enable_o     = en_q;
  assign serdes_rst_o = srst_q;

endmodule

// File: rtl/adrv9001_tdd_ctrl.sv
// ADRV9001 TDD sequencer: frame counter, run FSM, TX/RX windows.
// Ports: tdd_en_i start/abort, frame/window timing inputs (latched
// at start), channel enables, SERDES resets, busy/done/cfg_err, frame_idx.
module adrv9001_tdd_ctrl
  import adrv9001_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int NFRM_WIDTH = NFRM_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tdd_en_i,
  input  logic [CNT_WIDTH-1:0]  frame_len_i,
  input  logic [NFRM_WIDTH-1:0] num_frames_i,
  input  logic [CNT_WIDTH-1:0]  tx_on_i,
  input  logic [CNT_WIDTH-1:0]  tx_off_i,
  input  logic [CNT_WIDTH-1:0]  tx_ssi_on_i,
  input  logic [CNT_WIDTH-1:0]  rx_on_i,
  input  logic [CNT_WIDTH-1:0]  rx_off_i,
  input  logic [CNT_WIDTH-1:0]  rx_ssi_on_i,
  output logic                  tx_enable_o,
  output logic                  rx_enable_o,
  output logic                  tx_serdes_rst_o,
  output logic                  rx_serdes_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o,
  output logic [NFRM_WIDTH-1:0] frame_idx_o
);

  tdd_state_e state_q, state_d;

  logic en_q;
  logic armed_q;
  logic cfg_err_q;
  logic start, cfg_ok, go;
  logic wrap, last_wrap, win_run;

  logic [CNT_WIDTH-1:0]  cnt_q, flen_q;
  logic [CNT_WIDTH-1:0]  tx_on_q, tx_off_q, tx_ssi_q;
  logic [CNT_WIDTH-1:0]  rx_on_q, rx_off_q, rx_ssi_q;
  logic [NFRM_WIDTH-1:0] nfrm_q, fidx_q;

  // armed_q blocks a start until tdd_en has been seen low,
  // so a level held high across reset cannot launch a run.
  assign start = tdd_en_i && !en_q && armed_q
              && (state_q == ST_IDLE);

  assign cfg_ok = (frame_len_i >= CNT_WIDTH'(2))
               && (tx_off_i <= frame_len_i)
               && (rx_off_i <= frame_len_i)
               && (tx_on_i < tx_off_i)
               && (rx_on_i < rx_off_i)
               && (tx_ssi_on_i <= tx_off_i)
               && (rx_ssi_on_i <= rx_off_i);

  assign go = start && cfg_ok;

  assign wrap      = (cnt_q == flen_q - CNT_WIDTH'(1));
  assign last_wrap = wrap && (nfrm_q != '0)
                  && (fidx_q == nfrm_q - NFRM_WIDTH'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go) state_d = ST_RUN;
      ST_RUN: begin
        if (!tdd_en_i)     state_d = ST_IDLE;
        else if (last_wrap) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (1'b1)
      (state_q == ST_RUN):  busy_o = 1'b1;
      (state_q == ST_DONE): done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_q      <= 1'b0;
      armed_q   <= !tdd_en_i;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
      fidx_q    <= '0;
      flen_q    <= '0;
      nfrm_q    <= '0;
      tx_on_q   <= '0;
      tx_off_q  <= '0;
      tx_ssi_q  <= '0;
      rx_on_q   <= '0;
      rx_off_q  <= '0;
      rx_ssi_q  <= '0;
    end else begin
      en_q    <= tdd_en_i;
      armed_q <= armed_q || !tdd_en_i;
      if (start) cfg_err_q <= !cfg_ok;
      if (go) begin
        flen_q   <= frame_len_i;
        nfrm_q   <= num_frames_i;
        tx_on_q  <= tx_on_i;
        tx_off_q <= tx_off_i;
        tx_ssi_q <= tx_ssi_on_i;
        rx_on_q  <= rx_on_i;
        rx_off_q <= rx_off_i;
        rx_ssi_q <= rx_ssi_on_i;
        cnt_q    <= '0;
        fidx_q   <= '0;
      end else if (state_q == ST_RUN) begin
        if (wrap) begin
          cnt_q <= '0;
          // The final frame keeps its index for readback.
          if (!last_wrap) fidx_q <= fidx_q + NFRM_WIDTH'(1);
        end else begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Gate on staying in RUN so the first RUN cycle and the
  // cycle after leaving RUN both show idle window values.
  assign win_run = (state_q == ST_RUN) && (state_d == ST_RUN);

  adrv9001_tdd_window #(.CNT_WIDTH(CNT_WIDTH)) u_tx_win (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cnt_i        (cnt_q),
    .on_i         (tx_on_q),
    .off_i        (tx_off_q),
    .ssi_on_i     (tx_ssi_q),
    .run_i        (win_run),
    .enable_o     (tx_enable_o),
    .serdes_rst_o (tx_serdes_rst_o)
  );

  adrv9001_tdd_window #(.CNT_WIDTH(CNT_WIDTH)) u_rx_win (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cnt_i        (cnt_q),
    .on_i         (rx_on_q),
    .off_i        (rx_off_q),
    .ssi_on_i     (rx_ssi_q),
    .run_i        (win_run),
    .enable_o     (rx_enable_o),
    .serdes_rst_o (rx_serdes_rst_o)
  );

  assign cfg_err_o   = cfg_err_q;
  assign frame_idx_o = fidx_q;

endmodule

// File: tb/tb_adrv9001_tdd_ctrl.sv
// Self-checking bench for adrv9001_tdd_ctrl.
// Config-check vector table plus directed multi-cycle sequences.
module tb_adrv9001_tdd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        tdd_en;
  logic [31:0] frame_len;
  logic [15:0] num_frames;
  logic [31:0] tx_on, tx_off, tx_ssi_on;
  logic [31:0] rx_on, rx_off, rx_ssi_on;
  logic        tx_enable, rx_enable;
  logic        tx_serdes_rst, rx_serdes_rst;
  logic        busy, done, cfg_err;
  logic [15:0] frame_idx;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  adrv9001_tdd_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .tdd_en_i        (tdd_en),
    .frame_len_i     (frame_len),
    .num_frames_i    (num_frames),
    .tx_on_i         (tx_on),
    .tx_off_i        (tx_off),
    .tx_ssi_on_i     (tx_ssi_on),
    .rx_on_i         (rx_on),
    .rx_off_i        (rx_off),
    .rx_ssi_on_i     (rx_ssi_on),
    .tx_enable_o     (tx_enable),
    .rx_enable_o     (rx_enable),
    .tx_serdes_rst_o (tx_serdes_rst),
    .rx_serdes_rst_o (rx_serdes_rst),
    .busy_o          (busy),
    .done_o          (done),
    .cfg_err_o       (cfg_err),
    .frame_idx_o     (frame_idx)
  );

  typedef struct {
    logic [31:0] flen;
    logic [31:0] ton, toff, tssi;
    logic [31:0] ron, roff, rssi;
    logic        err;
  } cfg_vec_t;

  cfg_vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic set_cfg(input int fl, input int nf,
                         input int a, input int b, input int c,
                         input int d, input int e, input int f);
    frame_len  = 32'(fl);
    num_frames = 16'(nf);
    tx_on      = 32'(a);
    tx_off     = 32'(b);
    tx_ssi_on  = 32'(c);
    rx_on      = 32'(d);
    rx_off     = 32'(e);
    rx_ssi_on  = 32'(f);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".busy"}, int'(busy), 0);
    chk({nm, ".done"}, int'(done), 0);
    chk({nm, ".tx_en"}, int'(tx_enable), 0);
    chk({nm, ".rx_en"}, int'(rx_enable), 0);
    chk({nm, ".tx_srst"}, int'(tx_serdes_rst), 1);
    chk({nm, ".rx_srst"}, int'(rx_serdes_rst), 1);
  endtask

  initial begin
    int c;
    bit act;

    vecs[0] = '{1,  0, 1, 0,  0, 1, 0,  1'b1};
    vecs[1] = '{10, 5, 5, 1,  3, 8, 2,  1'b1};
    vecs[2] = '{10, 2, 6, 1,  3, 8, 2,  1'b0};
    vecs[3] = '{10, 2, 11, 1, 3, 8, 2,  1'b1};
    vecs[4] = '{10, 2, 6, 7,  3, 8, 2,  1'b1};
    vecs[5] = '{10, 2, 6, 1,  8, 8, 2,  1'b1};
    vecs[6] = '{2,  0, 2, 2,  1, 2, 0,  1'b0};
    vecs[7] = '{2,  0, 2, 0,  0, 3, 0,  1'b1};

    // Reset with tdd_en already high.
    rst    = 1'b1;
    tdd_en = 1'b1;
    set_cfg(10, 0, 2, 6, 1, 4, 10, 0);
    repeat (3) step();
    chk_idle("rst");
    chk("rst.cfg_err", int'(cfg_err), 0);
    chk("rst.frame_idx", int'(frame_idx), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rel_high.busy", int'(busy), 0);
    end

    // Config validity table.
    for (int i = 0; i < 8; i++) begin
      tdd_en = 1'b0;
      step();
      step();
      set_cfg(int'(vecs[i].flen), 0,
              int'(vecs[i].ton), int'(vecs[i].toff), int'(vecs[i].tssi),
              int'(vecs[i].ron), int'(vecs[i].roff), int'(vecs[i].rssi));
      tdd_en = 1'b1;
      step();
      chk($sformatf("vec%0d.cfg_err", i), int'(cfg_err), int'(vecs[i].err));
      chk($sformatf("vec%0d.busy", i), int'(busy), int'(!vecs[i].err));
      tdd_en = 1'b0;
      step();
      step();
      chk($sformatf("vec%0d.sticky", i), int'(cfg_err), int'(vecs[i].err));
      chk($sformatf("vec%0d.idle", i), int'(busy), 0);
    end

    // Two 10-cycle frames; inputs scrambled mid-run.
    set_cfg(10, 2, 2, 6, 1, 4, 10, 0);
    tdd_en = 1'b0;
    step();
    step();
    tdd_en = 1'b1;
    step();
    chk("seq1.cfg_clr", int'(cfg_err), 0);
    for (int k = 0; k < 23; k++) begin
      act = (k >= 1) && (k <= 19);
      c = (k + 9) % 10;
      chk($sformatf("seq1.busy@%0d", k), int'(busy), int'(k < 20));
      chk($sformatf("seq1.done@%0d", k), int'(done), int'(k == 20));
      chk($sformatf("seq1.tx_en@%0d", k), int'(tx_enable),
          int'(act && c >= 2 && c < 6));
      chk($sformatf("seq1.tx_srst@%0d", k), int'(tx_serdes_rst),
          int'(!(act && c >= 1 && c < 6)));
      chk($sformatf("seq1.rx_en@%0d", k), int'(rx_enable),
          int'(act && c >= 4 && c < 10));
      chk($sformatf("seq1.rx_srst@%0d", k), int'(rx_serdes_rst),
          int'(!act));
      chk($sformatf("seq1.fidx@%0d", k), int'(frame_idx),
          (k < 20) ? k / 10 : 1);
      if (k == 12) set_cfg(3, 0, 0, 9, 0, 0, 2, 2);
      step();
    end

    // Continuous run, then drop tdd_en.
    set_cfg(4, 0, 0, 4, 0, 0, 4, 0);
    tdd_en = 1'b0;
    step();
    step();
    tdd_en = 1'b1;
    step();
    for (int k = 0; k < 50; k++) begin
      chk($sformatf("seq2.fidx@%0d", k), int'(frame_idx), k / 4);
      chk($sformatf("seq2.busy@%0d", k), int'(busy), 1);
      if (k == 49) tdd_en = 1'b0;
      step();
    end
    chk_idle("seq2.abort");
    chk("seq2.fidx_hold", int'(frame_idx), 12);
    step();
    chk("seq2.done_late", int'(done), 0);

    // Abort on the final wrap.
    set_cfg(4, 2, 0, 4, 0, 1, 3, 1);
    step();
    tdd_en = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("seq3.busy@%0d", k), int'(busy), 1);
      if (k == 7) begin
        chk("seq3.tx_en_pre", int'(tx_enable), 1);
        chk("seq3.fidx_pre", int'(frame_idx), 1);
        tdd_en = 1'b0;
      end
      step();
    end
    chk_idle("seq3.abort");
    step();
    chk("seq3.done_late", int'(done), 0);
    chk("seq3.busy_late", int'(busy), 0);

    // Reset mid-frame with tdd_en held high.
    set_cfg(10, 0, 2, 6, 1, 4, 10, 0);
    step();
    tdd_en = 1'b1;
    step();
    repeat (5) step();
    chk("seq4.busy_pre", int'(busy), 1);
    chk("seq4.fidx_pre", int'(frame_idx), 0);
    rst = 1'b1;
    step();
    chk_idle("seq4.rst");
    chk("seq4.cfg_err", int'(cfg_err), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("seq4.hold@%0d", i), int'(busy), 0);
    end
    tdd_en = 1'b0;
    step();
    chk("seq4.low", int'(busy), 0);
    tdd_en = 1'b1;
    step();
    chk("seq4.restart", int'(busy), 1);
    chk("seq4.fidx", int'(frame_idx), 0);
    tdd_en = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
